mem_port_arbiter: RTL and testbench

- Shares one picorv32-style native memory port (valid/ready, instr, addr, wdata, wstrb, rdata) between NREQ requesters, e.g. two cores or a core plus a debug/loader master, in formal and simulation harnesses.
- Round-robin grant; a grant is held for exactly one transaction.
- A bounded-wait watchdog and a protocol checker expose sticky flags usable as bench assumptions/assertions.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_rr_picker.sv | 26 ++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the native memory-port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  typedef struct packed {
    logic              instr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_req_t;

  // Width needed to index n items; never below 1 so a 1-bit pointer exists for n<=2.
  function automatic int clog2(input int n);
    for (int w = 1; w < 32; w++)
      if ((1 << w) >= n) return w;
    return 32;
  endfunction

endpackage

// File: rtl/mem_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module mem_rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic            valid
);

  // Scan by distance from ptr so every index stays a constant; works for non-power-of-2 NREQ.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int k = 0; k < NREQ; k++)
      for (int i = 0; i < NREQ; i++)
        if (!valid && req[i] && (((i - int'(ptr)) + NREQ) % NREQ) == k) begin
          pick[i] = 1'b1;
          valid   = 1'b1;
        end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one picorv32-style memory port, one transaction per grant,
// with a sticky wait watchdog and a sticky early-drop protocol flag.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int MAX_WAIT = 16,
  parameter int WCNT_W   = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_instr,
  input  logic [ADDR_W*NREQ-1:0]   req_addr,
  input  logic [DATA_W*NREQ-1:0]   req_wdata,
  input  logic [STRB_W*NREQ-1:0]   req_wstrb,
  output logic [NREQ-1:0]          req_ready,
  output logic [DATA_W-1:0]        req_rdata,
  output logic                     mem_valid,
  output logic                     mem_instr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [STRB_W-1:0]        mem_wstrb,
  input  logic                     mem_ready,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic                     timeout,
  output logic                     proto_err
);

  localparam int PW = clog2(NREQ);
  localparam logic [WCNT_W-1:0] WMAX  = WCNT_W'(MAX_WAIT);
  localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(MAX_WAIT - 1);

  state_t              state, state_nx;
  logic [NREQ-1:0]     grant_nx, pick;
  logic [PW-1:0]       rr_ptr, ptr_nx, g_idx, ptr_adv;
  logic [WCNT_W-1:0]   wait_cnt, wcnt_nx;
  logic                tmo_nx, perr_nx, pick_vld, g_valid;
  mem_req_t            reqs [NREQ];
  mem_req_t            sel;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign reqs[i] = '{instr: req_instr[i],
                       addr:  req_addr[ADDR_W*i +: ADDR_W],
                       wdata: req_wdata[DATA_W*i +: DATA_W],
                       wstrb: req_wstrb[STRB_W*i +: STRB_W]};
  end

  mem_rr_picker #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .pick  (pick),
    .valid (pick_vld)
  );

  always_comb begin
    sel     = '0;
    g_idx   = '0;
    g_valid = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) begin
        sel     = reqs[i];
        g_idx   = PW'(i);
        g_valid = req_valid[i];
      end
  end

  assign ptr_adv   = (int'(g_idx) == NREQ - 1) ? '0 : g_idx + PW'(1);
  assign busy      = (state == BUSY);
  assign mem_valid = busy & g_valid;
  assign mem_instr = busy ? sel.instr : 1'b0;
  assign mem_addr  = busy ? sel.addr  : '0;
  assign mem_wdata = busy ? sel.wdata : '0;
  assign mem_wstrb = busy ? sel.wstrb : '0;
  assign req_ready = busy ? (grant & {NREQ{mem_ready}}) : '0;
  assign req_rdata = mem_rdata;

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    ptr_nx   = rr_ptr;
    wcnt_nx  = wait_cnt;
    tmo_nx   = timeout;
    perr_nx  = proto_err;
    case (state)
      IDLE: if (pick_vld) begin
        state_nx = BUSY;
        grant_nx = pick;
      end
      BUSY: if (mem_ready || !g_valid) begin
        // Completion and early-drop abort both release the port the same way.
        state_nx = IDLE;
        grant_nx = '0;
        ptr_nx   = ptr_adv;
        wcnt_nx  = '0;
        if (!mem_ready) perr_nx = 1'b1;
      end else begin
        if (wait_cnt != WMAX)  wcnt_nx = wait_cnt + WCNT_W'(1);
        if (wait_cnt == WLAST) tmo_nx  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      wait_cnt  <= '0;
      timeout   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nx;
      grant     <= grant_nx;
      rr_ptr    <= ptr_nx;
      wait_cnt  <= wcnt_nx;
      timeout   <= tmo_nx;
      proto_err <= perr_nx;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with NREQ=2, MAX_WAIT=16.
module tb_mem_port_arbiter;

  logic        clk, reset;
  logic [1:0]  req_valid, req_instr, req_ready, grant;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic [31:0] req_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_valid, mem_instr, mem_ready, busy, timeout, proto_err;
  int          n_cmp = 0;
  int          n_err = 0;

  mem_port_arbiter #(.NREQ(2), .MAX_WAIT(16), .WCNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_instr(req_instr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .req_rdata(req_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .grant(grant), .busy(busy), .timeout(timeout), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_instr = '0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; mem_ready = 1'b0; mem_rdata = '0;
    #2;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mvalid", 32'(mem_valid), 0);
    chk("rst_flags", 32'({timeout, proto_err}), 0);
    @(negedge clk);
    reset = 1'b0;

    // single requester read
    req_valid = 2'b01; req_instr = 2'b01; req_addr[31:0] = 32'h100;
    tick();
    chk("s1_grant", 32'(grant), 32'b01);
    chk("s1_busy", 32'(busy), 1);
    chk("s1_mvalid", 32'(mem_valid), 1);
    chk("s1_maddr", mem_addr, 32'h100);
    chk("s1_minstr", 32'(mem_instr), 1);
    chk("s1_mwstrb", 32'(mem_wstrb), 0);
    chk("s1_rdy_wait", 32'(req_ready), 0);
    tick(); tick();
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("s1_rdy", 32'(req_ready), 32'b01);
    chk("s1_rdata", req_rdata, 32'hDEADBEEF);
    tick();
    req_valid = '0; mem_ready = 1'b0;
    chk("s1_idle", 32'({busy, grant}), 0);
    chk("s1_tmo", 32'(timeout), 0);

    // mem_ready while idle is ignored
    mem_ready = 1'b1;
    #1;
    chk("idle_rdy", 32'(req_ready), 0);
    chk("idle_mvalid", 32'(mem_valid), 0);
    tick();
    chk("idle_busy", 32'(busy), 0);
    mem_ready = 1'b0;

    // fairness: rr_ptr is 1 after requester 0 completed
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("rr_grant", 32'(grant), (t % 2 == 0) ? 32'b10 : 32'b01);
      chk("rr_mvalid", 32'(mem_valid), 1);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      if (t == 3) req_valid = '0;
      chk("rr_gap", 32'(busy), 0);
    end

    // write passthrough from requester 1 (rr_ptr=1)
    req_valid = 2'b10; req_instr = 2'b01;
    req_addr  = {32'h2000_0004, 32'h100};
    req_wdata = {32'h1234_5678, 32'hAAAA_5555};
    req_wstrb = {4'hF, 4'h3};
    tick();
    chk("wr_grant", 32'(grant), 32'b10);
    chk("wr_addr", mem_addr, 32'h2000_0004);
    chk("wr_wdata", mem_wdata, 32'h1234_5678);
    chk("wr_wstrb", 32'(mem_wstrb), 32'hF);
    chk("wr_instr", 32'(mem_instr), 0);
    mem_ready = 1'b1;
    #1;
    chk("wr_rdy", 32'(req_ready), 32'b10);
    tick();
    req_valid = '0; mem_ready = 1'b0;

    // watchdog (rr_ptr=0)
    req_valid = 2'b01;
    tick();
    chk("wd_grant", 32'(grant), 32'b01);
    repeat (15) tick();
    chk("wd_tmo15", 32'(timeout), 0);
    tick();
    chk("wd_tmo16", 32'(timeout), 1);
    chk("wd_busy", 32'(busy), 1);
    mem_ready = 1'b1;
    #1;
    chk("wd_rdy", 32'(req_ready), 32'b01);
    tick();
    req_valid = '0; mem_ready = 1'b0;
    chk("wd_done", 32'(busy), 0);
    chk("wd_sticky", 32'(timeout), 1);

    // protocol error (rr_ptr=1, only requester 0 asks)
    req_valid = 2'b01;
    tick();
    chk("pe_grant", 32'(grant), 32'b01);
    req_valid = 2'b00;
    #1;
    chk("pe_mvalid", 32'(mem_valid), 0);
    tick();
    chk("pe_flag", 32'(proto_err), 1);
    chk("pe_idle", 32'({busy, grant}), 0);
    req_valid = 2'b11;
    tick();
    chk("pe_ptr1", 32'(grant), 32'b10);

    // async reset in the middle of a wait; rr_ptr is still 1 here
    tick();
    #2;
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    chk("ar_mvalid", 32'(mem_valid), 0);
    chk("ar_grant", 32'(grant), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_rdy", 32'(req_ready), 0);
    chk("ar_flags", 32'({timeout, proto_err}), 0);
    #1;
    reset = 1'b0; mem_ready = 1'b0;
    tick();
    chk("ar_ptr0", 32'(grant), 32'b01);
    mem_ready = 1'b1;
    tick();
    req_valid = '0; mem_ready = 1'b0;
    chk("ar_done", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
